// File: rtl/types_pkg.sv
// Shared types for the display shifter: FSM state encoding and frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package types_pkg;

    // Number of serial bits per display frame.
    localparam int DISP_BITS = 256;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        CAPT     = 6'b000010,
        SHIFT_LO = 6'b000100,
        SHIFT_HI = 6'b001000,
        LATCH    = 6'b010000,
        DONE     = 6'b100000
    } disp_shift_t;

endpackage

// File: rtl/disp_pwm.sv
// Brightness PWM for the driver output enable: 8-bit free-running counter.
// Latency: disp_oe_n reflects disp_ena/disp_bright one cycle later (registered).
// Backpressure: none; runs continuously.
// Ports: clk, rst_n (async active-low), disp_ena, disp_bright[7:0] in;
//        disp_oe_n out (active low, low while pwm_cnt < disp_bright).
module disp_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_ena,
    input  logic [7:0] disp_bright,
    output logic       disp_oe_n
);

    logic [7:0] pwm_cnt_q;
    logic       oe_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 8'd0;
            oe_n_q    <= 1'b1;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            // bright=0 never enables; bright=255 enables 255 of 256 counts.
            oe_n_q    <= ~(disp_ena && (pwm_cnt_q < disp_bright));
        end
    end

    assign disp_oe_n = oe_n_q;

endmodule

// File: rtl/disp_shift.sv
// Serial shifter for a 256-bit segment driver chain, one frame per ms tick.
// Latency: frame_done 2 + 512*CLK_DIV + LAT_CYC cycles after the tsc_1ppms cycle.
// Backpressure: none; a tick arriving while busy is dropped and flagged on overrun.
// Ports: clk, rst_n (async active-low), tsc_1ppms, disp_ena, disp_data[255:0],
//        disp_bright[7:0] in; disp_sclk, disp_sdo, disp_lat, disp_oe_n, busy,
//        frame_done, overrun out (all registered).
// Build option: define DISP_PWM_EN to drive disp_oe_n from a brightness PWM;
//        otherwise disp_oe_n is ~disp_ena delayed one cycle and disp_bright is unused.
module disp_shift
    import types_pkg::*;
#(
    parameter int CLK_DIV = 4,  // clk cycles per disp_sclk half-period (2..255)
    parameter int LAT_CYC = 4   // clk cycles disp_lat is held high
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tsc_1ppms,
    input  logic                 disp_ena,
    input  logic [DISP_BITS-1:0] disp_data,
    input  logic [7:0]           disp_bright,
    output logic                 disp_sclk,
    output logic                 disp_sdo,
    output logic                 disp_lat,
    output logic                 disp_oe_n,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] LAT_LAST = 8'(LAT_CYC - 1);

    disp_shift_t          state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [7:0]           bit_cnt_q, bit_cnt_d;
    logic [DISP_BITS-1:0] shadow_q, shadow_d;
    logic                 sclk_q, lat_q, busy_q, done_q, ovr_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (tsc_1ppms && disp_ena) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                shadow_d  = disp_data;
                bit_cnt_d = 8'd0;
                div_d     = 8'd0;
                state_d   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d     = 8'd0;
                    // Shifting only here keeps disp_sdo stable across both halves.
                    shadow_d  = {shadow_q[DISP_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    state_d   = (bit_cnt_q == 8'hFF) ? LATCH : SHIFT_LO;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                if (div_q == LAT_LAST) begin
                    div_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 8'd0;
            shadow_q  <= '0;
            sclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            sclk_q    <= (state_d == SHIFT_HI);
            lat_q     <= (state_d == LATCH);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            // busy_q covers every non-IDLE state, DONE included.
            ovr_q     <= tsc_1ppms && busy_q;
        end
    end

    assign disp_sclk  = sclk_q;
    // Shadow MSB is itself a flop, so the serial data stays a registered output.
    assign disp_sdo   = shadow_q[DISP_BITS-1];
    assign disp_lat   = lat_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

`ifdef DISP_PWM_EN
    disp_pwm u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_ena   (disp_ena),
        .disp_bright(disp_bright),
        .disp_oe_n  (disp_oe_n)
    );
`else
    logic oe_n_q;
    logic unused_bright;

    assign unused_bright = ^disp_bright;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_n_q <= 1'b1;
        end else begin
            oe_n_q <= ~disp_ena;
        end
    end

    assign disp_oe_n = oe_n_q;
`endif

endmodule

// File: doc/disp_shift.md
DISP_SHIFT -- requirements
Module: disp_shift

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per disp_sclk half-period (legal range 2..255).
REQ-002 The block SHALL have parameter LAT_CYC, default 4, meaning clk cycles disp_lat is held high.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tsc_1ppms  in  1  one-cycle millisecond pulse; frame start trigger.
REQ-006 disp_ena  in  1  display enable.
REQ-007 disp_data  in  256  segment data; byte i = disp_data[8i+7:8i].
REQ-008 disp_bright  in  8  brightness level; used only when DISP_PWM_EN is defined.
REQ-009 disp_sclk  out  1  serial clock to the segment driver chain.
REQ-010 disp_sdo  out  1  serial data.
REQ-011 disp_lat  out  1  driver latch strobe, active high.
REQ-012 disp_oe_n  out  1  driver output enable, active low.
REQ-013 busy  out  1  high while a frame is in progress.
REQ-014 frame_done  out  1  one-cycle pulse when a frame is latched.
REQ-015 overrun  out  1  one-cycle pulse when tsc_1ppms arrives while busy.

Function
REQ-016 The state machine SHALL have exactly these states: IDLE, CAPT, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-017 IDLE SHALL go to CAPT when tsc_1ppms=1 and disp_ena=1; otherwise it SHALL stay in IDLE.
REQ-018 CAPT SHALL copy disp_data into a 256-bit shadow register, clear the bit counter, and go to SHIFT_LO after exactly 1 cycle.
REQ-019 SHIFT_LO SHALL drive disp_sclk=0 and present shadow bit 255 on disp_sdo, then go to SHIFT_HI after CLK_DIV cycles.
REQ-020 SHIFT_HI SHALL drive disp_sclk=1 for CLK_DIV cycles, then shift the shadow left by 1 and increment the 8-bit bit counter.
REQ-021 After SHIFT_HI the machine SHALL go to LATCH if the bit counter was 255 before the increment; otherwise it SHALL go to SHIFT_LO.
REQ-022 Bits SHALL be sent MSB first: disp_data[255] first, disp_data[0] last, for exactly 256 rising edges of disp_sclk per frame.
REQ-023 disp_sdo SHALL be stable for the full SHIFT_LO and SHIFT_HI of each bit (setup and hold = CLK_DIV cycles each).
REQ-024 LATCH SHALL drive disp_sclk=0 and disp_lat=1 for LAT_CYC cycles, then go to DONE.
REQ-025 DONE SHALL pulse frame_done for 1 cycle and return to IDLE.
REQ-026 Frame length from the tsc_1ppms cycle to the frame_done cycle SHALL be 2 + 512*CLK_DIV + LAT_CYC cycles.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 tsc_1ppms while busy=1 SHALL be ignored for frame start and SHALL pulse overrun 1 cycle later; tsc_1ppms coincident with the DONE cycle also counts as an overrun.
REQ-029 disp_ena falling mid-frame SHALL NOT abort the frame; changes to disp_data after CAPT SHALL NOT affect the current frame.
REQ-030 All outputs SHALL be registered.
REQ-031 Without DISP_PWM_EN, disp_oe_n SHALL equal ~disp_ena delayed by 1 cycle.

Reset
REQ-032 On rst_n=0 the block SHALL go to IDLE immediately, including mid-frame, with no latch pulse issued.
REQ-033 Reset values SHALL be: disp_sclk=0, disp_sdo=0, disp_lat=0, disp_oe_n=1, busy=0, frame_done=0, overrun=0, shadow=0, bit counter=0, divider=0.

Configuration
REQ-034 With macro DISP_PWM_EN defined, an 8-bit free-running PWM counter SHALL run, and disp_oe_n SHALL be the registered value of ~(disp_ena && pwm_cnt < disp_bright).
REQ-035 With DISP_PWM_EN defined, disp_bright=0 SHALL keep the display dark and disp_bright=255 SHALL give a 255/256 duty.
REQ-036 Without DISP_PWM_EN, the disp_bright input SHALL be ignored and no PWM logic SHALL be synthesised.

Structure
REQ-037 types_pkg SHALL hold the disp_shift_t state enum (one-hot encoding) and the constant DISP_BITS=256.
REQ-038 The PWM logic SHALL be a sub-module disp_pwm, instantiated only under DISP_PWM_EN.

Verification
REQ-039 Bench SHALL apply disp_data={8'h1c,8'hce,...,8'hbc}, CLK_DIV=4, and one tsc_1ppms -> 256 bits sampled on sclk rise SHALL equal disp_data MSB first, and frame_done SHALL occur 2054 cycles after the pulse.
REQ-040 Bench SHALL pulse tsc_1ppms at cycle 100 of a frame -> overrun SHALL pulse once and the frame length SHALL be unchanged.
REQ-041 Bench SHALL change disp_data to all-ones and drop disp_ena at bit 10 -> all 256 original bits SHALL be sent and frame_done SHALL pulse.
REQ-042 Bench SHALL assert rst_n=0 at bit 128 -> outputs SHALL take reset values the same cycle, disp_lat SHALL never rise, and the next tsc_1ppms SHALL start a clean frame.
REQ-043 Bench SHALL hold disp_ena=0 and pulse tsc_1ppms -> busy SHALL stay 0 and disp_sclk SHALL not toggle.
REQ-044 With DISP_PWM_EN and disp_bright=64, bench SHALL run 256 cycles -> disp_oe_n SHALL be low exactly 64 of the 256 cycles; with disp_bright=0 it SHALL be low for none.
